// File: rtl/slow2fast_fifo_buffer.sv
// Slow-to-fast AXI-Stream bridge: samples a slow-phase source once per slow period
// and drains it to a full-rate sink through a small FIFO plus an output register.
module slow2fast_fifo_buffer #(
  parameter int DWIDTH     = 128,
  parameter int RATIO      = 2,
  parameter int DEPTH      = 2,
  parameter int SAMPLE_IDX = 0,
  parameter int RDY_IDX    = RATIO - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(RATIO)-1:0]     clk_cnt,
  input  logic [DWIDTH-1:0]            s_axis_tdata,
  input  logic [DWIDTH/8-1:0]          s_axis_tkeep,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [DWIDTH-1:0]            m_axis_tdata,
  output logic [DWIDTH/8-1:0]          m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int KW = DWIDTH / 8;
  localparam int EW = DWIDTH + KW + 1;
  localparam int CW = $clog2(RATIO);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [FW-1:0]     r_fill;
  logic              r_s_tready;
  logic              r_m_tvalid;
  logic [DWIDTH-1:0] r_m_tdata;
  logic [KW-1:0]     r_m_tkeep;
  logic              r_m_tlast;

  logic              w_accept;
  logic              w_ld;
  logic              w_fifo_ne;
  logic              w_pop;
  logic              w_bypass;
  logic              w_push;
  logic [FW-1:0]     w_fill_next;
  logic [PW-1:0]     w_wr_ptr_next;
  logic [PW-1:0]     w_rd_ptr_next;
  logic [EW-1:0]     w_in_beat;
  logic [EW-1:0]     w_head;

  assign w_in_beat = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  assign w_head    = r_mem[r_rd_ptr];

  assign w_accept  = (clk_cnt == CW'(SAMPLE_IDX)) && s_axis_tvalid && r_s_tready;
  assign w_ld      = m_axis_tready || !r_m_tvalid;
  assign w_fifo_ne = (r_fill != '0);
  assign w_pop     = w_ld && w_fifo_ne;
  // Bypass only when the FIFO is empty so ordering is preserved.
  assign w_bypass  = w_ld && !w_fifo_ne && w_accept;
  assign w_push    = w_accept && !w_bypass;

  assign w_fill_next   = r_fill + FW'(w_push) - FW'(w_pop);
  assign w_wr_ptr_next = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_next = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_beat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_s_tready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_next;
      end
      r_fill <= w_fill_next;
      // At most one push per slow period, so refreshing once per period cannot overflow.
      if (clk_cnt == CW'(RDY_IDX)) begin
        r_s_tready <= (w_fill_next < FW'(DEPTH));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_pop) begin
      r_m_tvalid <= 1'b1;
      {r_m_tlast, r_m_tkeep, r_m_tdata} <= w_head;
    end else if (w_bypass) begin
      r_m_tvalid <= 1'b1;
      {r_m_tlast, r_m_tkeep, r_m_tdata} <= w_in_beat;
    end else if (w_ld) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tlast  = r_m_tlast;
  assign fill_level    = r_fill;

endmodule

// File: doc/slow2fast_fifo_buffer.md
# slow2fast_fifo_buffer

Parametrised slow-to-fast temporal bridge in the channel-bounding path. An AXI-Stream source is phase-aligned to a slower clock, exactly RATIO times slower than `clk`. The block samples the source once per slow period at a programmable phase and delivers beats to a full-rate AXI-Stream sink. Between sample point and sink it has a DEPTH-entry FIFO, so bursts of sink back-pressure are absorbed without stalling the slow side every period. `s_axis_tready` changes only at one programmable phase, so it stays stable for the whole slow cycle.

## Interface
- DWIDTH, 128, data width in bits; multiple of 8.
- RATIO, 2, fast/slow clock ratio; ≥2.
- DEPTH, 2, FIFO entries, excluding the output register; ≥1; need not be a power of two.
- SAMPLE_IDX, 0, `clk_cnt` phase at which the source is sampled; <RATIO.
- RDY_IDX, RATIO-1, `clk_cnt` phase at which `s_axis_tready` is refreshed; <RATIO.
- clk  in  1  fast clock; one clock domain only.
- rst  in  1  reset, asynchronous, active-high.
- clk_cnt  in  $clog2(RATIO)  phase of the current fast cycle within the slow period; supplied externally.
- s_axis_tdata  in  DWIDTH  source data.
- s_axis_tkeep  in  DWIDTH/8  source byte enables.
- s_axis_tlast  in  1  source end of packet.
- s_axis_tvalid  in  1  source valid; held for the whole slow cycle.
- s_axis_tready  out  1  registered ready; changes only on the edge that ends an RDY_IDX cycle.
- m_axis_tdata  out  DWIDTH  sink data; registered.
- m_axis_tkeep  out  DWIDTH/8  sink byte enables; registered.
- m_axis_tlast  out  1  sink end of packet; registered.
- m_axis_tvalid  out  1  sink valid; registered.
- m_axis_tready  in  1  sink ready.
- fill_level  out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH, excluding the output register.

## Operation
- Accept: a beat is accepted when `clk_cnt==SAMPLE_IDX && s_axis_tvalid && s_axis_tready`. It is never accepted at any other phase. `tvalid` at other phases is ignored.
- Output register load condition: `ld = m_axis_tready | ~m_axis_tvalid`.
- Output register source priority when `ld` is true:
  - FIFO head, if `fill_level>0` (pop).
  - Otherwise the accepted input beat (bypass; FIFO untouched).
  - Otherwise `m_axis_tvalid<=0`; data fields hold their previous value.
- Push: an accepted beat is written to the FIFO when it is not bypassed, i.e. when `~ld` or `fill_level>0`.
- Simultaneous push and pop: both happen in the same cycle; `fill_level` is unchanged, and the pushed beat goes to the tail.
- FIFO storage: circular array with `wr_ptr` and `rd_ptr` in 0..DEPTH-1. Each pointer wraps explicitly from DEPTH-1 to 0, so non-power-of-two DEPTH is supported.
- Occupancy arithmetic: `fill_next = fill_level + push - pop`. Width $clog2(DEPTH+1); never exceeds DEPTH and never underflows.
- Ready refresh: at `clk_cnt==RDY_IDX`, `s_axis_tready <= (fill_next < DEPTH)`. At all other phases it holds its value.
- No-overflow guarantee: at most one push occurs per slow period, and between refreshes occupancy can only fall. The FIFO therefore never overflows, and no overflow flag exists.
- Ordering: beats leave in acceptance order, with no loss or duplication. `tkeep` and `tlast` travel with their data.
- Reset state (asynchronous, takes effect without waiting for a clock edge):
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tkeep=0`, `m_axis_tlast=0`.
  - `fill_level=0`, both pointers 0.
  - `s_axis_tready=1`.
  - FIFO contents are don't-care.
- Reset mid-operation: all buffered beats are discarded. Normal operation resumes on the first `clk` edge after `rst` falls, at whatever `clk_cnt` phase that is.

## Timing
- Bypass latency: a beat sampled in a SAMPLE_IDX cycle with `ld=1` and an empty FIFO appears on `m_axis_*` one `clk` edge later.
- FIFO latency: a buffered beat appears on the first edge at which `ld=1` and it is the FIFO head.
- Ready response: after `fill_level` reaches DEPTH, `s_axis_tready` falls at the end of the next RDY_IDX cycle. After space frees, it rises at the end of the next RDY_IDX cycle.
- When SAMPLE_IDX==RDY_IDX, a push in that cycle is included in `fill_next` for the refresh.
- Sustained throughput is one beat per slow period. The sink sees `m_axis_tvalid` for one fast cycle per beat when unstalled.

## Test plan
- Reset: assert `rst` mid-cycle with `clk` stopped.
  - Required immediately: `m_axis_tvalid=0`, `s_axis_tready=1`, `fill_level=0`, data/keep/last=0.
- Streaming (RATIO=2, DEPTH=2, `m_axis_tready=1`): source beats 0x00..0x09, all with `tkeep` all-ones, `tlast` on 0x09.
  - Each beat is on `m_axis` exactly one fast cycle, one edge after its SAMPLE_IDX cycle.
  - `fill_level` stays 0 and `s_axis_tready` stays 1.
  - `tvalid` pulses at phase 1 alone produce no output.
- Back-pressure (DEPTH=2, `m_axis_tready=0`): source sends A, B, C, D.
  - A is held in the output register; B and C go to the FIFO; `fill_level=2`.
  - `s_axis_tready` drops at the RDY_IDX cycle ending the slow cycle of C, so D is not accepted.
  - Release `tready`: output order is A, B, C, D; `s_axis_tready` returns to 1.
- Wrap (DEPTH=3, RATIO=4): 20 beats with `m_axis_tready` toggled in the pattern 3 cycles low / 5 cycles high.
  - Pointers wrap through 2→0 repeatedly.
  - Output equals input order; `fill_level` never exceeds 3.
- Simultaneous push/pop (`fill_level=1`): release `tready` in the SAMPLE_IDX cycle of beat X.
  - Head leaves, X is pushed, `fill_level` stays 1, and X follows next.
- Reset mid-operation (`fill_level=2`, output valid): pulse `rst` between edges.
  - All state clears at once; no old beat ever appears.
  - The first new beat after release takes the bypass path with 1-cycle latency.
